div_iter_unit: RTL and testbench
================================

Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring integer divider in the EXE stage, directly upstream of the CP0/HI-LO stage.
- Accepts a DIV/DIVU operation from EXE and iterates one quotient bit per cycle.
- Delivers a one-cycle `div_out_valid` pulse with `{quotient, remainder}` on `div_result`; the downstream stage loads quotient into LO and remainder into HI.
- Cancels cleanly on a pipeline flush from CP0.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W; iteration count equals DATA_W.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- div_start  in  1  request a new division; accepted only in IDLE
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start
- div_dividend  in  DATA_W  dividend; sampled with div_start
- div_divisor  in  DATA_W  divisor; sampled with div_start
- div_flush  in  1  cancel any in-flight operation (driven from CP0 flush)
- div_busy  out  1  high in every non-IDLE state
- div_out_valid  out  1  single-cycle completion pulse
- div_result  out  2*DATA_W  [2W-1:W] = quotient, [W-1:0] = remainder

Behaviour:
- Clock and reset (already decided): single clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset values: state = IDLE; div_busy = 0; div_out_valid = 0; div_result = 0; all internal registers = 0.
- States and transitions:
  - IDLE: on div_start & ~div_flush, capture operands and go to CALC; otherwise stay in IDLE.
  - CALC: counter counts 0..DATA_W-1, one restoring step per edge; after the last step go to SIGN.
  - SIGN: apply sign correction, register div_result, go to DONE.
  - DONE: div_out_valid = (state == DONE) & ~div_flush; go to IDLE on the next edge.
- Latency, with E0 the accepting edge: CALC spans E1..E32, SIGN ends at E33, and div_out_valid is high in the cycle after E33 (34 cycles after the start cycle).
- div_result holds its value until the next completion; flush never alters it.
- Restoring step:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem - |divisor| at DATA_W+1 bits.
  - If trial is non-negative: rem = trial and quotient bit = 1; otherwise quotient bit = 0.
- Signed operation:
  - Operate on absolute values.
  - Negate the quotient iff the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (no trap; overflow detection is not this block's job).
- Divide by zero, signed or unsigned: quotient = all-ones, remainder = dividend, normal latency.
- div_start while busy: ignored; no queueing.
- div_flush in any non-IDLE state: go to IDLE on the next edge with no valid pulse; in DONE it suppresses div_out_valid in the same cycle.
- div_flush and div_start together in IDLE: the start is not accepted.
- A new div_start is accepted in the same cycle that DONE returns to IDLE only if state == IDLE; back-to-back issue therefore has a one-cycle gap.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: DIV_ITER_EARLY_OUT_EN.
- Defined: in IDLE at acceptance, if divisor == 0 or |dividend| < |divisor|, skip CALC and go directly to SIGN with quotient = 0 (all-ones for divide by zero) and remainder = dividend. div_out_valid then rises 2 cycles after the start cycle.
- Not defined: every operation takes the full 34 cycles.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package: state encoding constants (IDLE, CALC, SIGN, DONE), DIV_ITER_CYCLES = DATA_W, DIV_ZERO_QUOTIENT = all-ones, and the result field bit positions so the HI/LO consumer uses the same slicing.
- Sub-module div_iter_step: purely combinational single restoring step (inputs rem, quo, divisor; outputs next rem, next quo). It is instantiated once; the FSM and counter stay in the top module.

Test Plan:
- Unsigned 100 / 7: div_out_valid 34 cycles after start, div_result = {32'd14, 32'd2}; div_busy high for 34 cycles.
- Signed -7 / 2 (0xFFFFFFF9, 0x2): result = {0xFFFFFFFD, 0xFFFFFFFF}. Signed 0x80000000 / 0xFFFFFFFF: result = {0x80000000, 0x00000000}.
- Divide by zero, DIVU 0x1234 / 0: result = {0xFFFFFFFF, 0x00001234}. With DIV_ITER_EARLY_OUT_EN, the same result arrives 2 cycles after start.
- Flush on cycle 10 of CALC: no valid pulse, div_busy drops the next cycle, div_result is unchanged. A new 50 / 5 issued afterwards returns {10, 0}.
- div_start pulsed during CALC with different operands: ignored; the original result is returned. div_start together with div_flush in IDLE: no acceptance, div_busy stays 0.
- Assert resetn low asynchronously mid-CALC: outputs go to 0 immediately; after release a fresh 9 / 3 returns {3, 0}.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider and its HI/LO consumer.
// Optional early-out build is selected with DIV_ITER_EARLY_OUT_EN.
package div_iter_pkg;

  localparam int DIV_DATA_W      = 32;
  localparam int DIV_ITER_CYCLES = DIV_DATA_W;

  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOTIENT = '1;

  // div_result slicing: quotient -> LO, remainder -> HI
  localparam int DIV_QUO_MSB = 2*DIV_DATA_W-1;
  localparam int DIV_QUO_LSB = DIV_DATA_W;
  localparam int DIV_REM_MSB = DIV_DATA_W-1;
  localparam int DIV_REM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// One combinational restoring-division step on magnitudes.
module div_iter_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] rem_sh;
  logic       ge;

  // Shifted remainder can reach 2^W, so the compare carries the extra bit;
  // the subtraction result always fits back into W bits.
  assign rem_sh   = {rem, quo[W-1]};
  assign ge       = rem_sh >= {1'b0, divisor};
  assign rem_next = ge ? (rem_sh[W-1:0] - divisor) : rem_sh[W-1:0];
  assign quo_next = {quo[W-2:0], ge};

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring DIV/DIVU unit with flush cancel.
// Define DIV_ITER_EARLY_OUT_EN to skip iteration for trivial quotients.
//
// state | meaning
// IDLE  | waiting for div_start
// CALC  | one restoring step per clock, DATA_W steps
// SIGN  | sign fix-up, load div_result
// DONE  | div_out_valid pulse
module div_iter_unit
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                div_start,
  input  logic                div_signed,
  input  logic [DATA_W-1:0]   div_dividend,
  input  logic [DATA_W-1:0]   div_divisor,
  input  logic                div_flush,
  output logic                div_busy,
  output logic                div_out_valid,
  output logic [2*DATA_W-1:0] div_result
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rem_q, quo_q, dvs_q;
  logic                neg_quo_q, neg_rem_q, div_zero_q;
  logic [2*DATA_W-1:0] result_q;

  logic [DATA_W-1:0]   dvd_abs, dvs_abs, rem_nx, quo_nx, quo_fin, rem_fin;
  logic                accept, early_out, last_step;

  assign dvd_abs   = (div_signed && div_dividend[DATA_W-1]) ? -div_dividend : div_dividend;
  assign dvs_abs   = (div_signed && div_divisor[DATA_W-1])  ? -div_divisor  : div_divisor;
  assign last_step = cnt_q == CNT_W'(DATA_W-1);

`ifdef DIV_ITER_EARLY_OUT_EN
  assign early_out = (div_divisor == '0) || (dvd_abs < dvs_abs);
`else
  assign early_out = 1'b0;
`endif

  div_iter_step #(.W(DATA_W)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Divide by zero keeps the all-ones quotient regardless of operand signs.
  assign quo_fin = div_zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign rem_fin = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    div_busy      = (state_q != ST_IDLE);
    div_out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (div_start && !div_flush) begin
          accept  = 1'b1;
          state_d = early_out ? ST_SIGN : ST_CALC;
        end
      end
      ST_CALC: begin
        if (div_flush)      state_d = ST_IDLE;
        else if (last_step) state_d = ST_SIGN;
      end
      ST_SIGN: state_d = div_flush ? ST_IDLE : ST_DONE;
      ST_DONE: begin
        state_d       = ST_IDLE;
        div_out_valid = ~div_flush;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        cnt_q      <= '0;
        rem_q      <= early_out ? dvd_abs : '0;
        quo_q      <= early_out ? '0 : dvd_abs;
        dvs_q      <= dvs_abs;
        neg_quo_q  <= div_signed & (div_dividend[DATA_W-1] ^ div_divisor[DATA_W-1]);
        neg_rem_q  <= div_signed & div_dividend[DATA_W-1];
        div_zero_q <= (div_divisor == '0);
      end else if (state_q == ST_CALC) begin
        cnt_q <= cnt_q + 1'b1;
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end
      if (state_q == ST_SIGN && !div_flush)
        result_q <= {quo_fin, rem_fin};
    end
  end

  assign div_result = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Randomized self-checking bench for div_iter_unit against an arithmetic model.
module tb_div_iter_unit;
  import div_iter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_dividend = '0;
  logic [31:0] div_divisor = '0;
  logic        div_flush = 1'b0;
  logic        div_busy;
  logic        div_out_valid;
  logic [63:0] div_result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  div_iter_unit #(.DATA_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_flush     (div_flush),
    .div_busy      (div_busy),
    .div_out_valid (div_out_valid),
    .div_result    (div_result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!sgn) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {q, r};
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_ITER_EARLY_OUT_EN
    logic [31:0] aa, bb;
    aa = (sgn && a[31]) ? 32'(0 - a) : a;
    bb = (sgn && b[31]) ? 32'(0 - b) : b;
    if (b == 0 || aa < bb) return 2;
`endif
    return DIV_ITER_CYCLES + 2;
  endfunction

  // Issue one operation; optionally flush or re-pulse div_start at a given busy cycle.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int flush_at, input int inject_at);
    logic [63:0] exp;
    int lat, seen, busy_cnt;
    exp = ref_div(sgn, a, b);
    lat = ref_lat(sgn, a, b);
    seen = 0;
    busy_cnt = 0;
    div_start = 1'b1;
    div_signed = sgn;
    div_dividend = a;
    div_divisor = b;
    @(posedge clk); #1;
    div_start = 1'b0;
    div_dividend = $urandom;
    div_divisor = $urandom;
    for (int c = 1; c <= 60; c++) begin
      if (flush_at > 0 && c == flush_at + 1) break;
      if (div_busy) busy_cnt++;
      if (div_out_valid) begin
        seen = c;
        break;
      end
      div_start = (c == inject_at);
      if (c == inject_at) begin
        div_signed = 1'($urandom_range(0, 1));
        div_dividend = $urandom;
        div_divisor = $urandom_range(1, 100);
      end
      div_flush = (c == flush_at);
      @(posedge clk); #1;
    end
    div_start = 1'b0;
    div_flush = 1'b0;
    if (flush_at > 0) begin
      chk({tag, " busy_after_flush"}, 64'(div_busy), 64'd0);
      chk({tag, " no_valid"}, 64'(seen), 64'd0);
      chk({tag, " result_kept"}, div_result, last_res);
    end else begin
      chk({tag, " latency"}, 64'(seen), 64'(lat));
      chk({tag, " result"}, div_result, exp);
      chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
      last_res = exp;
      @(posedge clk); #1;
      chk({tag, " pulse_end"}, {62'd0, div_out_valid, div_busy}, 64'd0);
    end
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {div_result[31:0], 30'd0, div_busy, div_out_valid}, 64'd0);
    chk("reset_result", div_result, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0, 0);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 0, 0);
    do_div("div_neg_by0", 1'b1, 32'hFFFF_FF00, 32'd0, 0, 0);
    do_div("divu_small", 1'b0, 32'd3, 32'd10, 0, 0);

    do_div("flush_calc", 1'b0, 32'd1000, 32'd3, 10, 0);
    do_div("div_50_5", 1'b0, 32'd50, 32'd5, 0, 0);
    do_div("start_ignored", 1'b0, 32'd12345, 32'd11, 0, 1);

    div_start = 1'b1;
    div_flush = 1'b1;
    div_dividend = 32'd77;
    div_divisor = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    div_flush = 1'b0;
    chk("start_with_flush_busy", 64'(div_busy), 64'd0);
    @(posedge clk); #1;
    chk("start_with_flush_idle", {62'd0, div_busy, div_out_valid}, 64'd0);

    div_start = 1'b1;
    div_signed = 1'b0;
    div_dividend = 32'd100;
    div_divisor = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {div_result, 62'd0, div_busy, div_out_valid}, '0);
    last_res = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_div("div_9_3", 1'b0, 32'd9, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: begin a = $urandom_range(0, 50); b = $urandom; end
        4: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      do_div("random", sgn, a, b, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
